serial_adder_ctrl: RTL and testbench

//  Sequencer that time-shares one 1-bit full adder (sum = a^b^c, carry = majority)
//  to add two WIDTH-bit operands bit-serially, LSB first, one bit per clock.

---
 rtl/serial_adder_ctrl.sv | 110 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder sequencer around a single 1-bit full adder.
// Adds two WIDTH-bit operands plus carry-in LSB first, one bit per clock.
// {cout, sum} is loaded together with the done pulse and holds until the next done.

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             c;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_c;

    // Shared full adder and the accumulator with the new sum bit entering at the MSB.
    always_comb begin
        fa_s    = a_sh[0] ^ b_sh[0] ^ c;
        fa_c    = (a_sh[0] & b_sh[0]) | (b_sh[0] & c) | (c & a_sh[0]);
        acc_nxt = (acc >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    end

    // Next-state logic: one accept from IDLE, WIDTH RUN cycles, one DONE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST_BIT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register with status outputs decoded from the next state so they are flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            ready <= (state_nxt == IDLE);
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == DONE);
        end
    end

    // Operand shifters, carry, bit counter and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        c    <= cin;
                        acc  <= '0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    c    <= fa_c;
                    acc  <= acc_nxt;
                    cnt  <= cnt + CNT_W'(1);
                    // Final bit: publish the result on the edge that enters DONE.
                    if (cnt == LAST_BIT) begin
                        sum  <= acc_nxt;
                        cout <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: randomized and directed checks of serial_adder_ctrl at WIDTH 8, 1 and 3
// against a plain-arithmetic reference (a + b + cin) and cycle-count expectations.

module tb_serial_adder_ctrl;

    logic clk;
    logic rst_n;

    logic       start8, cin8, ready8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, ready1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;
    logic       start3, cin3, ready3, busy3, done3, cout3;
    logic [2:0] a3, b3, sum3;

    logic        done_x  [3];
    logic        ready_x [3];
    logic        busy_x  [3];
    logic        cout_x  [3];
    logic [31:0] sum_x   [3];

    int errors;
    int checks;

    serial_adder_ctrl #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_adder_ctrl #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );
    serial_adder_ctrl #(.WIDTH(3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .ready(ready3), .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
    );

    assign done_x[0]  = done8;   assign done_x[1]  = done1;   assign done_x[2]  = done3;
    assign ready_x[0] = ready8;  assign ready_x[1] = ready1;  assign ready_x[2] = ready3;
    assign busy_x[0]  = busy8;   assign busy_x[1]  = busy1;   assign busy_x[2]  = busy3;
    assign cout_x[0]  = cout8;   assign cout_x[1]  = cout1;   assign cout_x[2]  = cout3;
    assign sum_x[0]   = 32'(sum8);
    assign sum_x[1]   = 32'(sum1);
    assign sum_x[2]   = 32'(sum3);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: the full-width arithmetic sum, bit w is the carry-out.
    function automatic logic [32:0] ref_add(input logic [31:0] av, input logic [31:0] bv,
                                            input logic ci);
        return 33'(av) + 33'(bv) + 33'(ci);
    endfunction

    task automatic set_in(input int idx, input logic s, input logic [31:0] av,
                          input logic [31:0] bv, input logic ci);
        case (idx)
            0:       begin start8 = s; a8 = 8'(av); b8 = 8'(bv); cin8 = ci; end
            1:       begin start1 = s; a1 = 1'(av); b1 = 1'(bv); cin1 = ci; end
            default: begin start3 = s; a3 = 3'(av); b3 = 3'(bv); cin3 = ci; end
        endcase
    endtask

    // One operation on instance idx (width w); inj >= 0 pulses a competing start mid-run.
    task automatic run_op(input string tag, input int idx, input int w,
                          input logic [31:0] av, input logic [31:0] bv, input logic ci,
                          input int inj);
        logic [32:0] r;
        logic [31:0] mask;
        logic [31:0] prev;
        int cyc, busy_cnt, extra;
        bit held, rdy_bad;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        r    = ref_add(av & mask, bv & mask, ci);
        @(negedge clk);
        prev = sum_x[idx];
        set_in(idx, 1'b1, av, bv, ci);
        @(negedge clk);
        set_in(idx, 1'b0, $urandom, $urandom, 1'($urandom));
        cyc = 0; held = 1; rdy_bad = 0;
        busy_cnt = busy_x[idx] ? 1 : 0;
        if (ready_x[idx]) rdy_bad = 1;
        while (!done_x[idx] && cyc < 40) begin
            if (cyc == inj) set_in(idx, 1'b1, 32'hFF, 32'hFF, 1'b1);
            else            set_in(idx, 1'b0, av, bv, ci);
            @(negedge clk);
            cyc++;
            if (busy_x[idx])  busy_cnt++;
            if (ready_x[idx]) rdy_bad = 1;
            if (!done_x[idx] && sum_x[idx] !== prev) held = 0;
        end
        set_in(idx, 1'b0, 32'h0, 32'h0, 1'b0);
        check({tag, "_latency"}, 32'(cyc), 32'(w));
        check({tag, "_sum"}, sum_x[idx], r[31:0] & mask);
        check({tag, "_cout"}, 32'(cout_x[idx]), 32'(r[w]));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(w + 1));
        check({tag, "_sum_held"}, 32'(held), 32'd1);
        if (inj >= 0) check({tag, "_ready_low"}, 32'(rdy_bad), 32'd0);
        @(negedge clk);
        check({tag, "_idle_ready"}, 32'(ready_x[idx]), 32'd1);
        check({tag, "_idle_done"}, 32'(done_x[idx]), 32'd0);
        if (inj >= 0) begin
            extra = 0;
            for (int k = 0; k < 2 * w; k++) begin
                @(negedge clk);
                if (done_x[idx]) extra++;
            end
            check({tag, "_no_extra_done"}, 32'(extra), 32'd0);
        end
    endtask

    logic [7:0] ta [50];
    logic [7:0] tb [50];
    logic       tc [50];

    initial begin
        logic [32:0] r;
        int cyc, dcount;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        set_in(0, 1'b0, 0, 0, 0);
        set_in(1, 1'b0, 0, 0, 0);
        set_in(2, 1'b0, 0, 0, 0);
        @(negedge clk);
        set_in(0, 1'b1, 32'h55, 32'h66, 1'b1);
        @(negedge clk);
        check("rst_ready", 32'(ready8), 32'd1);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        check("rst_w1_ready", 32'(ready1), 32'd1);
        set_in(0, 1'b0, 0, 0, 0);
        rst_n = 1'b1;

        // Directed values
        run_op("t1_zero", 0, 8, 32'h00, 32'h00, 1'b0, -1);
        run_op("t2_ff01", 0, 8, 32'hFF, 32'h01, 1'b0, -1);
        run_op("t2_a55a", 0, 8, 32'hA5, 32'h5A, 1'b1, -1);
        run_op("t2_3c0f", 0, 8, 32'h3C, 32'h0F, 1'b0, -1);
        run_op("t3_overlap", 0, 8, 32'h12, 32'h34, 1'b0, 3);
        for (int i = 0; i < 6; i++)
            run_op("rnd8", 0, 8, 32'($urandom_range(255)), 32'($urandom_range(255)),
                   1'($urandom), -1);

        // Reset in the middle of an operation
        @(negedge clk);
        set_in(0, 1'b1, 32'hF0, 32'h0F, 1'b1);
        @(negedge clk);
        set_in(0, 1'b0, 0, 0, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t4_busy", 32'(busy8), 32'd0);
        check("t4_done", 32'(done8), 32'd0);
        check("t4_sum", 32'(sum8), 32'd0);
        check("t4_cout", 32'(cout8), 32'd0);
        check("t4_ready", 32'(ready8), 32'd1);
        dcount = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done8) dcount++;
        end
        check("t4_no_done", 32'(dcount), 32'd0);
        run_op("t4_after", 0, 8, 32'h01, 32'h01, 1'b0, -1);

        // Back-to-back with start held: accepts at edges 0, 10, 20, ...
        for (int i = 0; i < 50; i++) begin
            ta[i] = 8'($urandom);
            tb[i] = 8'($urandom);
            tc[i] = 1'($urandom);
            set_in(0, 1'b1, 32'(ta[i]), 32'(tb[i]), tc[i]);
            @(negedge clk);
            check("t5_done", 32'(done8), 32'((i % 10) == 8));
            if ((i % 10) == 8) begin
                r = ref_add(32'(ta[i - 8]), 32'(tb[i - 8]), tc[i - 8]);
                check("t5_sum", 32'(sum8), 32'(r[7:0]));
                check("t5_cout", 32'(cout8), 32'(r[8]));
            end
        end
        set_in(0, 1'b0, 0, 0, 0);
        cyc = 0;
        while (!ready8 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_drain", 32'(ready8), 32'd1);

        // Exhaustive small widths
        for (int v = 0; v < 8; v++)
            run_op("t6_w1", 1, 1, 32'((v >> 2) & 1), 32'((v >> 1) & 1), 1'(v & 1), -1);
        for (int v = 0; v < 128; v++)
            run_op("t6_w3", 2, 3, 32'((v >> 4) & 7), 32'((v >> 1) & 7), 1'(v & 1), -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
